// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: calculator register bank (R0 = accumulator) with an edge-triggered command sequencer.
// Optional UNDO shadow bank is built when the macro REGBANK_UNDO_EN is defined.
module reg_bank_ctrl #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned NREG  = 4,
  parameter int unsigned KW    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [2:0]              op_i,
  input  logic [KW-1:0]           k_i,
  input  logic                    perform_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [NREG*WIDTH-1:0]   r_o
);

  localparam logic [2:0] OP_INIT  = 3'b000;
  localparam logic [2:0] OP_CLR   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_SWAP  = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_UNDO  = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_INIT_WALK = 1'b1
  } state_e;

  state_e            state_q;
  logic              perform_q;
  logic [KW-1:0]     idx_q;
  logic [WIDTH-1:0]  regs_q [NREG];
  logic [WIDTH-1:0]  regs_d [NREG];
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept_s;
  logic              k_ok_s;
  logic              uses_k_s;
  logic              illegal_s;
  logic              reject_s;
  logic              last_s;

`ifdef REGBANK_UNDO_EN
  logic [WIDTH-1:0]  shadow_q [NREG];
  logic              undo_valid_q;
  logic              modify_s;
`endif

  function automatic logic [WIDTH-1:0] idx_val(input logic [KW-1:0] i);
    return WIDTH'(i);
  endfunction

  // Command decode: edge detect, index range check and rejection.
  always_comb begin
    accept_s  = perform_i && !perform_q && (state_q == S_IDLE);
    k_ok_s    = (32'(k_i) < NREG);
    last_s    = (32'(idx_q) == (NREG - 32'd1));
    uses_k_s  = 1'b0;
    illegal_s = 1'b0;
    case (op_i)
      OP_LOAD, OP_STORE, OP_SWAP, OP_INC, OP_DEC: uses_k_s = 1'b1;
      OP_UNDO: begin
`ifdef REGBANK_UNDO_EN
        illegal_s = !undo_valid_q;
`else
        illegal_s = 1'b1;
`endif
      end
      default: uses_k_s = 1'b0;
    endcase
    reject_s = (uses_k_s && !k_ok_s) || illegal_s;
`ifdef REGBANK_UNDO_EN
    modify_s = accept_s && !reject_s && (op_i != OP_UNDO);
`endif
  end

  // Next register bank: INIT walk write or single-edge command result.
  always_comb begin
    regs_d = regs_q;
    if (state_q == S_INIT_WALK) begin
      regs_d[idx_q] = idx_val(idx_q);
    end else if (accept_s && !reject_s) begin
      case (op_i)
        OP_CLR:   regs_d[0] = '0;
        OP_LOAD:  regs_d[0] = regs_q[k_i];
        OP_STORE: regs_d[k_i] = regs_q[0];
        OP_SWAP: begin
          regs_d[0]   = regs_q[k_i];
          regs_d[k_i] = regs_q[0];
        end
        OP_INC:   regs_d[k_i] = regs_q[k_i] + WIDTH'(1'b1);
        OP_DEC:   regs_d[k_i] = regs_q[k_i] - WIDTH'(1'b1);
        OP_UNDO: begin
`ifdef REGBANK_UNDO_EN
          regs_d = shadow_q;
`else
          regs_d = regs_q;
`endif
        end
        default:  regs_d = regs_q;
      endcase
    end else begin
      regs_d = regs_q;
    end
  end

  // Sequencer FSM, handshake outputs and register bank storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      perform_q <= 1'b1;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      perform_q <= perform_i;
      regs_q    <= regs_d;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            if (!reject_s && (op_i == OP_INIT)) begin
              state_q <= S_INIT_WALK;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
              err_q   <= reject_s;
            end
          end
        end
        S_INIT_WALK: begin
          idx_q <= idx_q + KW'(1'b1);
          if (last_s) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGBANK_UNDO_EN
  // Shadow bank captured at the accept edge of every modifying command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      undo_valid_q <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (modify_s) begin
      shadow_q     <= regs_q;
      undo_valid_q <= 1'b1;
    end else if (accept_s && !reject_s && (op_i == OP_UNDO)) begin
      undo_valid_q <= 1'b0;
    end
  end
`endif

  // Flatten the bank onto the output bus.
  always_comb begin
    r_o = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      r_o[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: a 4-register and a 3-register instance share one stimulus stream.
module tb_reg_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        perform = 1'b1;
  logic [2:0]  op = 3'b000;
  logic [1:0]  k = 2'd0;
  logic        busy4, done4, err4;
  logic        busy3, done3, err3;
  logic [19:0] r4;
  logic [14:0] r3;

  reg_bank_ctrl #(.WIDTH(5), .NREG(4), .KW(2)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .k_i(k), .perform_i(perform),
    .busy_o(busy4), .done_o(done4), .err_o(err4), .r_o(r4)
  );

  reg_bank_ctrl #(.WIDTH(5), .NREG(3), .KW(2)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .k_i(k), .perform_i(perform),
    .busy_o(busy3), .done_o(done3), .err_o(err3), .r_o(r3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc4 = -1;
  logic [20:0] q4 [$];
  logic [15:0] q3 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: each Done pulse is compared against the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [20:0] e4;
    logic [15:0] e3;
    if (rst_n && done4) begin
      done_cyc4 = cyc;
      if (q4.size() == 0) begin
        check("dut4_unexpected_done", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        check("dut4_r", {12'd0, r4}, {12'd0, e4[19:0]});
        check("dut4_err", {31'd0, err4}, {31'd0, e4[20]});
      end
    end
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        check("dut3_unexpected_done", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        check("dut3_r", {17'd0, r3}, {17'd0, e3[14:0]});
        check("dut3_err", {31'd0, err3}, {31'd0, e3[15]});
      end
    end
  end

  function automatic logic [19:0] v4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [14:0] v3(input int a, input int b, input int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic drain(input int exp_busy4, input bit timed);
    int b4;
    int acc;
    int n;
    acc = cyc;
    b4 = 0;
    n = 0;
    while ((q4.size() != 0 || q3.size() != 0) && n < 30) begin
      if (busy4) b4++;
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      check("drain_timeout", 32'(q4.size() + q3.size()), 32'd0);
      q4.delete();
      q3.delete();
    end else if (timed) begin
      check("busy4_cycles", 32'(b4), 32'(exp_busy4));
      check("done4_latency", 32'(done_cyc4 - acc), 32'(exp_busy4));
    end
  endtask

  task automatic cmd(input logic [2:0] o, input logic [1:0] kk,
                     input logic [20:0] e4, input logic [15:0] e3, input int exp_busy4);
    @(negedge clk);
    op = o;
    k = kk;
    perform = 1'b1;
    done_cyc4 = -1;
    q4.push_back(e4);
    q3.push_back(e3);
    @(negedge clk);
    perform = 1'b0;
    drain(exp_busy4, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dcount;
    rst_n = 1'b0;
    perform = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done4 || done3) dcount++;
    end
    check("no_done_after_reset", 32'(dcount), 32'd0);
    check("reset_r4", {12'd0, r4}, 32'd0);
    check("reset_r3", {17'd0, r3}, 32'd0);
    check("reset_busy", {30'd0, busy4, busy3}, 32'd0);
    perform = 1'b0;

    cmd(3'b000, 2'd0, {1'b0, v4(0, 1, 2, 3)},   {1'b0, v3(0, 1, 2)},   4);
    cmd(3'b100, 2'd2, {1'b0, v4(2, 1, 0, 3)},   {1'b0, v3(2, 1, 0)},   0);
    cmd(3'b001, 2'd0, {1'b0, v4(0, 1, 0, 3)},   {1'b0, v3(0, 1, 0)},   0);
    cmd(3'b110, 2'd0, {1'b0, v4(31, 1, 0, 3)},  {1'b0, v3(31, 1, 0)},  0);
    cmd(3'b011, 2'd3, {1'b0, v4(31, 1, 0, 31)}, {1'b1, v3(31, 1, 0)},  0);
    cmd(3'b101, 2'd3, {1'b0, v4(31, 1, 0, 0)},  {1'b1, v3(31, 1, 0)},  0);
    cmd(3'b110, 2'd1, {1'b0, v4(31, 0, 0, 0)},  {1'b0, v3(31, 0, 0)},  0);
    cmd(3'b110, 2'd1, {1'b0, v4(31, 31, 0, 0)}, {1'b0, v3(31, 31, 0)}, 0);
    cmd(3'b010, 2'd3, {1'b0, v4(0, 31, 0, 0)},  {1'b1, v3(31, 31, 0)}, 0);
    cmd(3'b101, 2'd2, {1'b0, v4(0, 31, 1, 0)},  {1'b0, v3(31, 31, 1)}, 0);
`ifdef REGBANK_UNDO_EN
    cmd(3'b111, 2'd0, {1'b0, v4(0, 31, 0, 0)},  {1'b0, v3(31, 31, 0)}, 0);
    cmd(3'b111, 2'd0, {1'b1, v4(0, 31, 0, 0)},  {1'b1, v3(31, 31, 0)}, 0);
`else
    cmd(3'b111, 2'd0, {1'b1, v4(0, 31, 1, 0)},  {1'b1, v3(31, 31, 1)}, 0);
    cmd(3'b111, 2'd3, {1'b1, v4(0, 31, 1, 0)},  {1'b1, v3(31, 31, 1)}, 0);
`endif

    // INIT with a second request raised mid-walk; it must be dropped.
    @(negedge clk);
    op = 3'b000;
    k = 2'd0;
    perform = 1'b1;
    q4.push_back({1'b0, v4(0, 1, 2, 3)});
    q3.push_back({1'b0, v3(0, 1, 2)});
    @(negedge clk);
    perform = 1'b0;
    @(negedge clk);
    op = 3'b010;
    k = 2'd1;
    perform = 1'b1;
    @(negedge clk);
    perform = 1'b0;
    drain(0, 1'b0);
    repeat (6) @(negedge clk);
    check("drop_r4", {12'd0, r4}, {12'd0, v4(0, 1, 2, 3)});
    check("drop_r3", {17'd0, r3}, {17'd0, v3(0, 1, 2)});

    cmd(3'b101, 2'd1, {1'b0, v4(0, 2, 2, 3)}, {1'b0, v3(0, 2, 2)}, 0);
    cmd(3'b011, 2'd0, {1'b0, v4(0, 2, 2, 3)}, {1'b0, v3(0, 2, 2)}, 0);

    // Reset during walk cycle 2 clears everything at once.
    @(negedge clk);
    op = 3'b000;
    k = 2'd0;
    perform = 1'b1;
    @(negedge clk);
    perform = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("walk_busy_before_reset", {31'd0, busy4}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_r4", {12'd0, r4}, 32'd0);
    check("abort_r3", {17'd0, r3}, 32'd0);
    check("abort_busy", {30'd0, busy4, busy3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd(3'b000, 2'd0, {1'b0, v4(0, 1, 2, 3)}, {1'b0, v3(0, 1, 2)}, 4);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Parametrised calculator register bank with an edge-triggered command sequencer. It holds NREG working registers of WIDTH bits, with R0 as the accumulator, and executes transfer and modify commands, including a multi-cycle INIT walk. It sits between the keypad/op decoder, which drives OP, K and Perform, and the ALU/display path, which reads the flattened register outputs.

## Interface
- WIDTH, 5, bits per register
- NREG, 4, number of registers (2..16)
- KW, 2, width of register index K; must satisfy 2^KW >= NREG
- Clock  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- OP  in  3  command code
- K  in  KW  target register index
- Perform  in  1  command request; acted on at its rising edge only
- Busy  out  1  high while a multi-cycle command runs
- Done  out  1  one-cycle pulse when a command completes, including rejected commands
- Err  out  1  one-cycle pulse, coincident with Done, for a rejected command
- R  out  NREG*WIDTH  flattened registers; R[i*WIDTH +: WIDTH] = Ri

## Operation
- Perform_q holds Perform delayed one cycle.
- A command is accepted at a clock edge when Perform=1, Perform_q=0 and the FSM is IDLE. OP and K are captured at that edge.
- Rising edges of Perform while Busy are dropped; they are not queued.
- Commands:
  - 000 INIT: Ri <= i mod 2^WIDTH for every i; multi-cycle.
  - 001 CLR: R0 <= 0.
  - 010 LOAD: R0 <= Rk.
  - 011 STORE: Rk <= R0; k=0 is a no-op that still completes normally.
  - 100 SWAP: R0 <= Rk and Rk <= R0 in the same edge.
  - 101 INC: Rk <= Rk+1, wraps modulo 2^WIDTH.
  - 110 DEC: Rk <= Rk-1, wraps modulo 2^WIDTH.
  - 111 UNDO when REGBANK_UNDO_EN is defined; otherwise illegal.
- Rejection: K >= NREG (for ops using K) or an illegal OP → no register changes, Err=1 and Done=1 for one cycle.
- FSM states:
  - IDLE → INIT_WALK on an accepted INIT; idx <= 0.
  - INIT_WALK: each edge writes R[idx] <= idx and increments idx. After writing idx=NREG-1 → IDLE, with Done pulsed in the following cycle.
  - All other commands complete in IDLE in one edge.

## Timing
- Reset values: all Ri=0, Busy=0, Done=0, Err=0, FSM=IDLE, idx=0.
- Perform_q resets to 1, so a Perform held high across reset release does not trigger a command.
- Single-cycle commands: registers update at the accept edge t; Done (and Err, if rejected) is high for the cycle after t; Busy stays 0.
- INIT: Busy goes high after accept edge t and stays high for NREG cycles. Ri updates at edge t+1+i. Busy falls and Done rises after edge t+NREG.
- Earliest next accept: the edge after Done is observed, which requires Perform to go low and then high again.
- Reset asserted mid-INIT aborts immediately to the reset values; partially written registers are cleared.
- All arithmetic is unsigned, WIDTH bits, with the carry discarded.

## Configuration
- REGBANK_UNDO_EN defined:
  - A shadow bank plus a valid flag are built in.
  - Every accepted, non-rejected modifying command (INIT, CLR, LOAD, STORE, SWAP, INC, DEC) copies the whole bank into the shadow at its accept edge and sets valid.
  - UNDO with valid=1 restores all registers from the shadow in one edge and clears valid.
  - UNDO with valid=0 is rejected with Err.
  - Reset clears valid.
- REGBANK_UNDO_EN undefined: no shadow logic; OP 111 is always rejected with Err.

## Test plan
- Reset release with Perform held at 1 → no Done; all R = 0. Then pulse Perform with INIT → Busy high for 4 cycles, R0..R3 = 0,1,2,3, a single Done pulse.
- After INIT, SWAP with K=2 → R0=2, R2=0 at the accept edge; Done high one cycle later; Busy stays 0.
- Run STORE K=3 while R0=31, then INC K=3 → R3 = 0 (wrap). Then DEC K=1 with R1=0 → R1 = 31.
- Start INIT, pulse Perform again (LOAD K=1) mid-walk → second request dropped; the final INIT values are unchanged; exactly one Done.
- Assert Reset at walk cycle 2 of INIT → all R = 0 and Busy = 0 immediately. The next INIT completes normally.
- With NREG=3, KW=2: LOAD K=3 → Err and Done pulse, no register change. With UNDO_EN: CLR after INIT, then UNDO → R0=0 restored to 0, R1..R2 intact, then a second UNDO → Err. Without UNDO_EN: OP 111 → Err.
